// File: rtl/async_reset_shift_reg_vec.sv
// async_reset_shift_reg_vec: W-bit, DEPTH-stage async-reset shift register with sync clear and warm-up valid
module async_reset_shift_reg_vec #(
  parameter int W = 1,
  parameter int DEPTH = 3,
  parameter logic [63:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] q,
  output logic         valid
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [W-1:0] IV = INIT[W-1:0];
  if (W < 1 || W > 64) begin : g_bad_w
    $error("async_reset_shift_reg_vec: W out of range 1..64");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("async_reset_shift_reg_vec: DEPTH out of range 1..16");
  end
  logic [W-1:0] stage [DEPTH];
  logic [FW-1:0] fill;
  // valid is the registered form of the next-state compare fill == DEPTH
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= IV;
      fill <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= IV;
      fill <= '0;
      valid <= 1'b0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      fill <= (fill == FULL) ? fill : fill + 1'b1;
      valid <= (fill >= FULL - 1'b1);
    end
  assign q = stage[DEPTH-1];
endmodule

// File: tb/tb_async_reset_shift_reg_vec.sv
// tb_async_reset_shift_reg_vec: scoreboard bench for the 4x3 INIT=A build and the 1x1 INIT=1 build
module tb_async_reset_shift_reg_vec;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] d = '0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic [3:0] q;
  logic valid;
  logic d1 = 1'b0;
  logic q1;
  logic valid1;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic [3:0] q;
    logic v;
    logic q1;
    logic v1;
  } exp_t;
  exp_t sb [$];
  exp_t e;
  logic [3:0] ms [3];
  int mf;
  logic m1q;
  int m1f;
  always #5 clk = ~clk;
  async_reset_shift_reg_vec #(.W(4), .DEPTH(3), .INIT(64'hA)) u_dut (
    .clk(clk), .rst(rst), .d(d), .en(en), .clear(clear), .q(q), .valid(valid)
  );
  async_reset_shift_reg_vec #(.W(1), .DEPTH(1), .INIT(64'h1)) u_dut1 (
    .clk(clk), .rst(rst), .d(d1), .en(en), .clear(clear), .q(q1), .valid(valid1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) ms[i] = 4'hA;
    mf = 0;
    m1q = 1'b1;
    m1f = 0;
  endtask
  task automatic step(input logic [3:0] dv, input logic ev, input logic cv);
    d = dv;
    en = ev;
    clear = cv;
    d1 = ~dv[0];
    if (cv) model_reset();
    else if (ev) begin
      ms[2] = ms[1];
      ms[1] = ms[0];
      ms[0] = dv;
      mf = (mf < 3) ? mf + 1 : 3;
      m1q = ~dv[0];
      m1f = 1;
    end
    sb.push_back('{ms[2], mf == 3, m1q, m1f == 1});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q", q, e.q);
    chk("valid", valid, e.v);
    chk("q1", q1, e.q1);
    chk("valid1", valid1, e.v1);
  endtask
  task automatic async_rst_check(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_q"}, q, 4'hA);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_q1"}, q1, 1'b1);
    chk({tag, "_valid1"}, valid1, 1'b0);
  endtask
  initial begin
    #2;
    async_rst_check("rst_init");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) step(4'(i), 1'b1, 1'b0);
    chk("fill_q_edge4", q, 4'h2);
    for (int i = 0; i < 5; i++) step(4'(i[0] ? 4'hF : 4'h0), 1'b0, 1'b0);
    chk("gate_hold_q", q, 4'h2);
    step(4'h5, 1'b1, 1'b0);
    step(4'h6, 1'b1, 1'b0);
    step(4'h7, 1'b1, 1'b0);
    chk("resume_q", q, 4'h5);
    step(4'h0, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    chk("pre_clear_q", q, 4'h7);
    chk("pre_clear_valid", valid, 1'b1);
    step(4'h5, 1'b1, 1'b1);
    step(4'h1, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    chk("clear_stage0", q, 4'hA);
    #2;
    async_rst_check("rst_midfill");
    #4;
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) step(4'(i + 8), 1'b1, 1'b0);
    chk("refill_q", q, 4'hC);
    #3;
    async_rst_check("rst_full");
    #4;
    rst = 1'b0;
    step(4'h3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h4, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
